// File: rtl/cdb_alu2_broadcaster_pkg.sv
// Shared CDB widths and payload bundle for the ALU2 result channel.
package cdb_alu2_broadcaster_pkg;

  localparam int unsigned REGNAME_W    = 6;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned COMMIT_TAG_W = 6;

  // One queued result, as seen by reservation entries and the commit unit
  typedef struct packed {
    logic [REGNAME_W-1:0]    regname;
    logic                    writeback;
    logic [DATA_W-1:0]       data;
    logic [COMMIT_TAG_W-1:0] tag;
  } cdb_entry_t;

  // Full CDB broadcast: valid qualifier plus result
  typedef struct packed {
    logic       valid;
    cdb_entry_t entry;
  } cdb_payload_t;

  // Build a broadcast; an invalid broadcast carries an all-zero payload
  function automatic cdb_payload_t cdb_pack(input logic valid, input cdb_entry_t entry);
    cdb_payload_t p;
    p = '0;
    if (valid) begin
      p.valid = 1'b1;
      p.entry = entry;
    end
    return p;
  endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// In-order result queue: register array, head read combinationally, flushable.
module cdb_result_fifo
  import cdb_alu2_broadcaster_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  cdb_entry_t i_push_data,
  input  logic       i_pop,
  output cdb_entry_t o_head,
  output logic       o_empty,
  output logic       o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  cdb_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow regardless of caller qualification
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Pointer/count update; reset also wipes storage, flush only empties
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_alu2_broadcaster.sv
// ALU2 CDB transmitter: queues execute results and broadcasts one per cycle.
// Optional same-cycle bypass into an empty queue: MIST1032SA_CDB_BYPASS_EN.
module cdb_alu2_broadcaster
  import cdb_alu2_broadcaster_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    iCLOCK,
  input  logic                    iRESET_SYNC,
  input  logic                    iFLUSH,
  input  logic                    iEXE_VALID,
  output logic                    oEXE_LOCK,
  input  logic [REGNAME_W-1:0]    iEXE_DESTINATION_REGNAME,
  input  logic                    iEXE_WRITEBACK,
  input  logic [DATA_W-1:0]       iEXE_DATA,
  input  logic [COMMIT_TAG_W-1:0] iEXE_COMMIT_TAG,
  input  logic                    iCDB_LOCK,
  output logic                    oCDB_VALID,
  output logic [REGNAME_W-1:0]    oCDB_DESTINATION_REGNAME,
  output logic                    oCDB_WRITEBACK,
  output logic [DATA_W-1:0]       oCDB_DATA,
  output logic [COMMIT_TAG_W-1:0] oCDB_COMMIT_TAG
);

  cdb_entry_t   w_in;
  cdb_entry_t   w_head;
  cdb_payload_t w_out;
  logic         w_empty;
  logic         w_full;
  logic         w_fifo_valid;
  logic         w_push;
  logic         w_pop;

  assign w_in.regname   = iEXE_DESTINATION_REGNAME;
  assign w_in.writeback = iEXE_WRITEBACK;
  assign w_in.data      = iEXE_DATA;
  assign w_in.tag       = iEXE_COMMIT_TAG;

  assign w_fifo_valid = ~w_empty;
  assign w_pop        = w_fifo_valid & ~iCDB_LOCK & ~iFLUSH;

`ifdef MIST1032SA_CDB_BYPASS_EN
  logic w_bypass;

  // Empty queue and free channel: send the arriving result straight out
  assign w_bypass = w_empty & iEXE_VALID & ~iCDB_LOCK & ~iFLUSH;
  assign w_push   = iEXE_VALID & ~w_full & ~iFLUSH & ~w_bypass;

  // Broadcast select: bypassed input wins, else queue head, zero when idle
  always_comb begin
    w_out = cdb_pack(w_fifo_valid, w_head);
    if (w_bypass) begin
      w_out = cdb_pack(1'b1, w_in);
    end
  end
`else
  assign w_push = iEXE_VALID & ~w_full & ~iFLUSH;

  // Broadcast select: queue head, zero when idle
  always_comb begin
    w_out = cdb_pack(w_fifo_valid, w_head);
  end
`endif

  cdb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (iCLOCK),
    .i_rst       (iRESET_SYNC),
    .i_flush     (iFLUSH),
    .i_push      (w_push),
    .i_push_data (w_in),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign oEXE_LOCK                = w_full;
  assign oCDB_VALID               = w_out.valid;
  assign oCDB_DESTINATION_REGNAME = w_out.entry.regname;
  assign oCDB_WRITEBACK           = w_out.entry.writeback;
  assign oCDB_DATA                = w_out.entry.data;
  assign oCDB_COMMIT_TAG          = w_out.entry.tag;

endmodule

// File: doc/cdb_alu2_broadcaster.md
# cdb_alu2_broadcaster

Result-side transmitter for the ALU2 common-data-bus channel: takes completed results from the ALU2 execution stage, queues them in a small in-order buffer, and drives one broadcast per cycle onto the CDB channel snooped by every reservation-station entry and the commit unit. It sits between the ALU2 execute pipeline and the CDB. It provides backpressure toward execute when full, holds while the shared channel is locked, and discards all queued results on a pipeline flush.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- iCLOCK  in  1  clock; all state updates on rising edge
- iRESET_SYNC  in  1  synchronous reset, active-high
- iFLUSH  in  1  pipeline flush; discard every queued and arriving result
- iEXE_VALID  in  1  execute stage presents a result
- oEXE_LOCK  out  1  queue full; execute must hold its result
- iEXE_DESTINATION_REGNAME  in  6  physical destination register
- iEXE_WRITEBACK  in  1  result writes a register
- iEXE_DATA  in  32  result value
- iEXE_COMMIT_TAG  in  6  reorder tag
- iCDB_LOCK  in  1  channel granted to another producer this cycle
- oCDB_VALID  out  1  broadcast valid
- oCDB_DESTINATION_REGNAME  out  6
- oCDB_WRITEBACK  out  1
- oCDB_DATA  out  32
- oCDB_COMMIT_TAG  out  6

## Operation
- State: entry array [DEPTH], write pointer, read pointer (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits, range 0..DEPTH).
- Push = iEXE_VALID & !oEXE_LOCK & !iFLUSH. Pop = oCDB_VALID & !iCDB_LOCK & !iFLUSH.
- oEXE_LOCK = (count == DEPTH). Decoded from registered count only; no combinational path from iCDB_LOCK.
- oCDB_VALID = (count != 0). CDB payload is the head entry. When the queue is empty, all payload outputs are 0.
- Push and pop in the same cycle: count unchanged, both pointers advance. This cannot happen at full because lock blocks the push. It cannot happen at empty because there is no valid output.
- Results leave in arrival order. Entries with WRITEBACK=0 are still broadcast; consumers qualify on WRITEBACK, and the commit unit needs the tag.
- iCDB_LOCK high: head is held stable. All payload outputs stay unchanged until the pop.
- Priority: iRESET_SYNC > iFLUSH > push/pop.
  - iFLUSH: count and pointers go to 0 and a simultaneous push is dropped. oCDB_VALID reads 0 from the next cycle.
- Reset values: oCDB_VALID 0, oEXE_LOCK 0, all oCDB payload 0. Pointers and count are 0.
  - Reset mid-stream behaves exactly as a flush, and also clears the entry array.

## Timing
- Latency (default build): a result pushed at edge N drives the CDB in cycle N..N+1, i.e. it is visible immediately after edge N.
- Throughput: 1 broadcast per cycle while iCDB_LOCK is low.
- oEXE_LOCK asserts the cycle after the push that reaches DEPTH. It deasserts the cycle after the first pop from full.
- With iCDB_LOCK held for k cycles, the head stays on the bus for k+1 cycles. It is popped at the first edge with lock low.

## Configuration
- MIST1032SA_CDB_BYPASS_EN defined: an arriving result bypasses the queue when all of the following hold in the same cycle:
  - count == 0
  - iEXE_VALID
  - !iCDB_LOCK
  - !iFLUSH
- In that case the input payload drives the CDB combinationally in the same cycle with oCDB_VALID=1, and the result is not enqueued. This gives zero latency; ordering is safe because the queue is empty. If iCDB_LOCK is high, the result is enqueued normally.
- Not defined: outputs come only from the queue; latency is exactly 1 cycle; there is no input-to-output combinational path.

## Structure
- Shared package/include: REGNAME_W=6, DATA_W=32, COMMIT_TAG_W=6, and the CDB payload bundle (valid, regname, writeback, data, tag), so that the reservation entries and the commit unit use the same widths.
- Sub-module cdb_result_fifo: parameterised storage, pointers, count, full/empty, flush. It is a register array read combinationally at the head.
- The top level holds push/pop qualification, the bypass mux, and output zeroing.

## Test plan
- Reset then single push (regname 0x05, data 0xDEADBEEF, WB=1, tag 0x11), CDB lock low -> next cycle oCDB_VALID=1 with exact payload; following cycle oCDB_VALID=0.
- Four back-to-back pushes with DEPTH=4 and CDB lock high -> oEXE_LOCK=1 after the 4th. A 5th result is held by execute. Release lock -> four broadcasts in order on consecutive cycles. Lock drops one cycle after the first pop.
- CDB lock toggled 1,0,1,0 with 3 queued results -> each head is held stable while locked, and no result is lost or duplicated.
- Flush with 3 queued and a push in the same cycle -> oCDB_VALID=0 next cycle, count 0, and the pushed result is never broadcast.
- Push of a WB=0 result (tag 0x2A) -> broadcast with oCDB_WRITEBACK=0 and oCDB_COMMIT_TAG=0x2A.
- With MIST1032SA_CDB_BYPASS_EN: push into an empty queue with lock low -> payload appears the same cycle and no broadcast follows next cycle. Without the macro, the same stimulus broadcasts one cycle later.
